// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan sequencer: state encoding, default dead time,
// and the code-advance / wrap-detect functions used by the sequencer FSM.
package scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      BLANK = 2'd2
   } scan_state_t;

   localparam int BLANK_CYCLES_DEFAULT = 2;

   function automatic logic [1:0] next_code(input logic [1:0] cur, input logic down);
      return down ? (cur - 2'd1) : (cur + 2'd1);
   endfunction

   function automatic logic is_wrap(input logic [1:0] cur, input logic down);
      return down ? (cur == 2'b00) : (cur == 2'b11);
   endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter timing dwell and blank periods; tc is high while the count is zero.
// A load of N gives N+1 clocks until tc, decrement saturates at zero; no backpressure.
module scan_dwell_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             tc
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tc = (cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Sequences a 2-bit decoder select code through dwell (active) and blank (dead-time) periods.
// Outputs registered, one clock from decision edge; code only changes on blank entry.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               dir,
   input  logic               step,
   input  logic [DWELL_W-1:0] dwell,
   output logic [1:0]         code,
   output logic               active,
   output logic               wrap
);

   localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

   scan_state_t      state, state_nxt;
   logic [1:0]       code_nxt;
   logic             active_nxt;
   logic             wrap_nxt;
   logic             tmr_load;
   logic             tmr_dec;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_tc;
   logic [CNT_W-1:0] dwell_ld;
   logic [CNT_W-1:0] blank_ld;

   // Timer reaches tc after load_val+1 clocks, so periods are loaded as length-1.
   assign dwell_ld = (dwell == '0) ? '0 : (CNT_W'(dwell) - CNT_W'(1));
   assign blank_ld = CNT_W'(BLANK_CYCLES - 1);

   scan_dwell_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .tc       (tmr_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         code   <= 2'b00;
         active <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         state  <= state_nxt;
         code   <= code_nxt;
         active <= active_nxt;
         wrap   <= wrap_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      wrap_nxt  = 1'b0;
      tmr_load  = 1'b0;
      tmr_dec   = 1'b0;
      tmr_val   = '0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = DWELL;
               tmr_load  = 1'b1;
               tmr_val   = dwell_ld;
            end else if (step) begin
               state_nxt = BLANK;
               code_nxt  = next_code(code, dir);
               wrap_nxt  = is_wrap(code, dir);
               tmr_load  = 1'b1;
               tmr_val   = blank_ld;
            end
         end
         DWELL: begin
            if (!tmr_tc) begin
               tmr_dec = 1'b1;
            end else if (en) begin
               state_nxt = BLANK;
               code_nxt  = next_code(code, dir);
               wrap_nxt  = is_wrap(code, dir);
               tmr_load  = 1'b1;
               tmr_val   = blank_ld;
            end else begin
               state_nxt = IDLE;
            end
         end
         BLANK: begin
            // en is deliberately not examined here: blank always runs into dwell.
            if (!tmr_tc) begin
               tmr_dec = 1'b1;
            end else begin
               state_nxt = DWELL;
               tmr_load  = 1'b1;
               tmr_val   = dwell_ld;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      active_nxt = (state_nxt == DWELL);
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: per-cycle expected {active, wrap, code} traces.
module tb_scan_sequencer;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       dir;
   logic       step;
   logic [7:0] dwell;
   logic [1:0] code;
   logic       active;
   logic       wrap;

   int checks;
   int failures;

   // Trace entries are {active, wrap, code[1:0]} observed after each rising edge.
   localparam logic [3:0] EXP_UP [21] = '{
      4'b1000, 4'b1000, 4'b1000, 4'b0001, 4'b0001,
      4'b1001, 4'b1001, 4'b1001, 4'b0010, 4'b0010,
      4'b1010, 4'b1010, 4'b1010, 4'b0011, 4'b0011,
      4'b1011, 4'b1011, 4'b1011, 4'b0100, 4'b0000,
      4'b1000
   };
   localparam logic [3:0] EXP_DOWN [13] = '{
      4'b1000, 4'b0111, 4'b0011, 4'b1011, 4'b0010,
      4'b0010, 4'b1010, 4'b0001, 4'b0001, 4'b1001,
      4'b0000, 4'b0000, 4'b1000
   };
   localparam logic [3:0] EXP_ZERO [7] = '{
      4'b1000, 4'b0001, 4'b0001, 4'b1001, 4'b0010,
      4'b0010, 4'b1010
   };
   localparam logic [3:0] EXP_STEP [11] = '{
      4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b0001,
      4'b0010, 4'b0010, 4'b1010, 4'b1010, 4'b0010,
      4'b0010
   };
   localparam logic [3:0] EXP_DROP [8] = '{
      4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
      4'b0000, 4'b0000, 4'b0000
   };
   localparam logic [3:0] EXP_POST_RST [4] = '{
      4'b1000, 4'b1000, 4'b1000, 4'b0001
   };

   scan_sequencer #(
      .DWELL_W      (8),
      .BLANK_CYCLES (2)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .dir    (dir),
      .step   (step),
      .dwell  (dwell),
      .code   (code),
      .active (active),
      .wrap   (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] obs();
      return {active, wrap, code};
   endfunction

   // Holds reset for two cycles, then releases it on a falling edge with the given inputs.
   task automatic restart(input logic en_v, input logic dir_v, input logic [7:0] dwell_v);
      rst_n = 1'b0;
      en    = 1'b0;
      step  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      en    = en_v;
      dir   = dir_v;
      dwell = dwell_v;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      dir   = 1'b0;
      step  = 1'b1;
      dwell = 8'd3;
      repeat (3) @(negedge clk);
      checks++;
      if (code !== 2'b00) begin
         failures++;
         $display("FAIL reset_code got=%b exp=00", code);
      end
      checks++;
      if (active !== 1'b0) begin
         failures++;
         $display("FAIL reset_active got=%b exp=0", active);
      end
      checks++;
      if (wrap !== 1'b0) begin
         failures++;
         $display("FAIL reset_wrap got=%b exp=0", wrap);
      end
   endtask

   task automatic test_free_run_up();
      restart(1'b1, 1'b0, 8'd3);
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== EXP_UP[i]) begin
            failures++;
            $display("FAIL up[%0d] got=%b exp=%b", i, obs(), EXP_UP[i]);
         end
      end
   endtask

   task automatic test_free_run_down();
      restart(1'b1, 1'b1, 8'd1);
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== EXP_DOWN[i]) begin
            failures++;
            $display("FAIL down[%0d] got=%b exp=%b", i, obs(), EXP_DOWN[i]);
         end
      end
   endtask

   task automatic test_zero_dwell();
      restart(1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== EXP_ZERO[i]) begin
            failures++;
            $display("FAIL zero_dwell[%0d] got=%b exp=%b", i, obs(), EXP_ZERO[i]);
         end
      end
   endtask

   task automatic test_single_step();
      restart(1'b0, 1'b0, 8'd2);
      for (int i = 0; i < 11; i++) begin
         step = (i == 0) || (i == 5);
         @(negedge clk);
         checks++;
         if (obs() !== EXP_STEP[i]) begin
            failures++;
            $display("FAIL step[%0d] got=%b exp=%b", i, obs(), EXP_STEP[i]);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_en_drop();
      restart(1'b1, 1'b0, 8'd5);
      for (int i = 0; i < 8; i++) begin
         en = (i < 2);
         @(negedge clk);
         checks++;
         if (obs() !== EXP_DROP[i]) begin
            failures++;
            $display("FAIL en_drop[%0d] got=%b exp=%b", i, obs(), EXP_DROP[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      restart(1'b1, 1'b0, 8'd3);
      repeat (11) @(negedge clk);
      checks++;
      if (obs() !== 4'b1010) begin
         failures++;
         $display("FAIL pre_reset_dwell got=%b exp=1010", obs());
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 4'b0000) begin
         failures++;
         $display("FAIL async_reset got=%b exp=0000", obs());
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs() !== EXP_POST_RST[i]) begin
            failures++;
            $display("FAIL post_reset[%0d] got=%b exp=%b", i, obs(), EXP_POST_RST[i]);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      dir      = 1'b0;
      step     = 1'b0;
      dwell    = 8'd0;
      test_reset();
      test_free_run_up();
      test_free_run_down();
      test_zero_dwell();
      test_single_step();
      test_en_drop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
